// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch front end.
//   - fetch_state_e : fetch FSM encoding (RUN issues requests, FLUSH drops
//                     stale responses after a redirect)
//   - PC_INCR       : byte step between sequential instruction words
//   - PC_ALIGN_MASK : clears the byte offset of a redirect target
//   - opcode / ALU constants used by the decode and execute stages
// Optional feature macro used by fetch_unit: FETCH_ALIGN_CHECK_EN.
package fetch_unit_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_INCR       = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // Major opcodes (RV32I base encoding).
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // Address of the word following pc, wrapping modulo 2^32.
  function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
    return pc + PC_INCR;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the memory response path and the decoder.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push, wdata     : write one entry (ignored when full or when clearing)
//   pop             : drop the head entry (ignored when empty or clearing)
//   clear           : empty the buffer; wins over a same-cycle push/pop
//   rdata           : head entry, valid whenever count != 0
//   count           : number of stored entries (0..DEPTH)
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  input  logic                         clear,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    push_en  = push && (count_q != CW'(DEPTH));
    pop_en   = pop && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_en)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the top masks the head while count == 0.
  always_ff @(posedge clk) begin
    if (push_en && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers in-order
// responses with their PCs, and hands them to the decoder. A redirect
// reloads the fetch PC, empties the buffer and drops responses that are
// still in flight.
// Ports:
//   clk, reset                      : clock, async active-high reset
//   mem_req_valid/addr/ready        : request channel to instruction memory
//   mem_resp_valid/data             : in-order response, always accepted
//   redirect_valid/pc               : single-cycle branch/jump redirect
//   instr_valid/data/pc, instr_ready: decoder channel
//   fetch_fault                     : sticky misaligned-redirect flag
//   dbg_state                       : current fetch FSM state
// Optional feature: define FETCH_ALIGN_CHECK_EN to flag misaligned redirect
// targets and halt fetching until reset; otherwise the low two target bits
// are ignored and fetch_fault stays 0.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Once raised, mem_req_valid and mem_req_addr hold until transfer (a
// redirect may withdraw them); instr_data/instr_pc hold until popped.
// mem_resp_valid has no ready: every response is consumed the cycle it
// arrives.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  output logic         mem_req_valid,
  output logic [31:0]  mem_req_addr,
  input  logic         mem_req_ready,
  input  logic         mem_resp_valid,
  input  logic [31:0]  mem_resp_data,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         instr_valid,
  output logic [31:0]  instr_data,
  output logic [31:0]  instr_pc,
  input  logic         instr_ready,
  output logic         fetch_fault,
  output fetch_state_e dbg_state
);

  // Counters span 0..FIFO_DEPTH without wrapping.
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] fifo_count;
  logic [63:0]   fifo_rdata;
  logic          credit_ok, req_fire, resp_in, resp_keep, fifo_pop;
  logic          fault_stop;
  logic [31:0]   redirect_target;

  assign redirect_target = redirect_pc & PC_ALIGN_MASK;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q | (redirect_valid && (redirect_pc[1:0] != 2'b00));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fault_stop = fault_q;
`else
  assign fault_stop = 1'b0;
`endif

  assign fetch_fault = fault_stop;

  // In-flight requests plus buffered words never exceed the buffer depth,
  // so every response is guaranteed a slot.
  assign credit_ok = (32'(outstanding_q) + 32'(fifo_count)) < 32'(FIFO_DEPTH);

  assign mem_req_valid = !reset && (state_q == ST_RUN) && !redirect_valid &&
                         !fault_stop && credit_ok;
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A stray response with nothing outstanding is ignored.
  assign resp_in   = mem_resp_valid && (outstanding_q != '0);
  assign resp_keep = resp_in && (discard_q == '0);

  assign instr_valid = (fifo_count != '0);
  assign fifo_pop    = instr_valid && instr_ready;
  assign instr_data  = instr_valid ? fifo_rdata[31:0]  : 32'h0;
  assign instr_pc    = instr_valid ? fifo_rdata[63:32] : 32'h0;
  assign dbg_state   = state_q;

  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_in);
    fetch_pc_d    = req_fire  ? next_word_pc(fetch_pc_q) : fetch_pc_q;
    // resp_pc tracks the PC of the next response that will be kept.
    resp_pc_d     = resp_keep ? next_word_pc(resp_pc_q)  : resp_pc_q;
    discard_d     = discard_q;
    if (resp_in && (discard_q != '0)) discard_d = discard_q - CW'(1);
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      // Everything still in flight after this cycle belongs to the old path.
      discard_d  = outstanding_d;
    end
    state_d = (discard_d != '0) ? ST_FLUSH : ST_RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // The redirect clears the buffer, overriding any same-cycle push or pop.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (resp_keep),
    .wdata ({resp_pc_q, mem_resp_data}),
    .pop   (fifo_pop),
    .clear (redirect_valid),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit (FIFO_DEPTH=2, RESET_PC=0). Memory contents are
// word(addr) = {~addr[15:0], addr[15:0]}.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic         clk;
  logic         reset;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [31:0]  mem_resp_data;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         instr_valid;
  logic [31:0]  instr_data;
  logic [31:0]  instr_pc;
  logic         instr_ready;
  logic         fetch_fault;
  fetch_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] pend_q[$];
  int          budget = 0;
  bit          hold = 0;
  int          release_cnt = 0;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .fetch_fault    (fetch_fault),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_word(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Memory model: accepts while budget lasts, answers in order one cycle
  // later unless responses are held back.
  always @(negedge clk) begin
    if (!reset && mem_req_valid && mem_req_ready) begin
      pend_q.push_back(mem_req_addr);
      budget = budget - 1;
    end
  end

  always @(posedge clk) begin
    #2;
    mem_req_ready  = (budget > 0);
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    if (pend_q.size() != 0 && (!hold || release_cnt > 0)) begin
      if (hold) release_cnt = release_cnt - 1;
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(pend_q.pop_front());
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h data %h expected none",
                 instr_pc, instr_data);
      end else begin
        check("instr", {instr_pc, instr_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset          = 1'b1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;

    cyc(3);
    @(negedge clk);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instr_data", 64'(instr_data), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    check("rst_fault", 64'(fetch_fault), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_RUN));

    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("first_req_valid", 64'(mem_req_valid), 64'd1);
    check("first_req_addr", 64'(mem_req_addr), 64'h0);

    // Streaming: 1-cycle memory, decoder always ready.
    cyc(1);
    instr_ready = 1'b1;
    expect_word(32'h0);
    expect_word(32'h4);
    expect_word(32'h8);
    expect_word(32'hC);
    budget = 4;
    drain();
    check("stream_next_addr", 64'(mem_req_addr), 64'h10);

    // Decoder stalled: credit limit of two words.
    cyc(1);
    instr_ready = 1'b0;
    budget = 5;
    cyc(8);
    @(negedge clk);
    check("stall_accepts", 64'(budget), 64'd3);
    check("stall_req_valid", 64'(mem_req_valid), 64'd0);
    check("stall_instr_valid", 64'(instr_valid), 64'd1);
    check("stall_pc", 64'(instr_pc), 64'h10);
    check("stall_data", 64'(instr_data), 64'hFFEF_0010);
    cyc(4);
    @(negedge clk);
    check("stall_pc_held", 64'(instr_pc), 64'h10);
    check("stall_data_held", 64'(instr_data), 64'hFFEF_0010);
    check("stall_req_still_low", 64'(mem_req_valid), 64'd0);
    cyc(1);
    budget = 0;
    expect_word(32'h10);
    expect_word(32'h14);
    instr_ready = 1'b1;
    drain();

    // Redirect with two responses in flight.
    cyc(1);
    hold = 1'b1;
    budget = 2;
    cyc(4);
    @(negedge clk);
    check("inflight_accepts", 64'(budget), 64'd0);
    check("inflight_req_valid", 64'(mem_req_valid), 64'd0);
    check("inflight_state", 64'(dbg_state), 64'(ST_RUN));
    pulse_redirect(32'h100);
    @(negedge clk);
    check("flush_state", 64'(dbg_state), 64'(ST_FLUSH));
    check("flush_instr_valid", 64'(instr_valid), 64'd0);
    check("flush_req_valid", 64'(mem_req_valid), 64'd0);
    cyc(1);
    expect_word(32'h100);
    expect_word(32'h104);
    budget = 2;
    hold = 1'b0;
    drain();
    check("flush_back_run", 64'(dbg_state), 64'(ST_RUN));
    check("flush_next_addr", 64'(mem_req_addr), 64'h108);

    // Wrap of the fetch address at the top of the address space.
    expect_word(32'hFFFF_FFF8);
    expect_word(32'hFFFF_FFFC);
    expect_word(32'h0);
    expect_word(32'h4);
    budget = 4;
    pulse_redirect(32'hFFFF_FFF8);
    drain();
    check("wrap_next_addr", 64'(mem_req_addr), 64'h8);

    // Redirect coinciding with a pop and a response.
    cyc(1);
    instr_ready = 1'b0;
    hold = 1'b1;
    budget = 2;
    cyc(4);
    release_cnt = 1;
    cyc(2);
    @(negedge clk);
    check("coinc_setup_valid", 64'(instr_valid), 64'd1);
    check("coinc_setup_pc", 64'(instr_pc), 64'h8);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    instr_ready    = 1'b1;
    release_cnt    = 1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("coinc_instr_valid", 64'(instr_valid), 64'd0);
    check("coinc_state", 64'(dbg_state), 64'(ST_RUN));
    cyc(1);
    hold = 1'b0;
    expect_word(32'h200);
    budget = 1;
    drain();
    check("coinc_next_addr", 64'(mem_req_addr), 64'h204);

    // Misaligned redirect target.
`ifdef FETCH_ALIGN_CHECK_EN
    budget = 1;
    pulse_redirect(32'h102);
    cyc(4);
    @(negedge clk);
    check("misalign_fault", 64'(fetch_fault), 64'd1);
    check("misalign_req_valid", 64'(mem_req_valid), 64'd0);
    check("misalign_no_accept", 64'(budget), 64'd1);
    cyc(1);
    budget = 0;
`else
    expect_word(32'h100);
    budget = 1;
    pulse_redirect(32'h102);
    drain();
    check("misalign_fault", 64'(fetch_fault), 64'd0);
    check("misalign_next_addr", 64'(mem_req_addr), 64'h104);
`endif

    // Reset in the middle of outstanding requests.
    cyc(1);
    hold = 1'b1;
    budget = 2;
    cyc(4);
    reset = 1'b1;
    pend_q.delete();
    budget = 0;
    hold = 1'b0;
    @(negedge clk);
    check("midrst_req_valid", 64'(mem_req_valid), 64'd0);
    check("midrst_instr_valid", 64'(instr_valid), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'(ST_RUN));
    check("midrst_fault", 64'(fetch_fault), 64'd0);
    cyc(1);
    reset = 1'b0;
    @(negedge clk);
    check("postrst_req_valid", 64'(mem_req_valid), 64'd1);
    check("postrst_req_addr", 64'(mem_req_addr), 64'h0);
    cyc(1);
    expect_word(32'h0);
    budget = 1;
    drain();

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
